// File: rtl/mp_alu_pkg.sv
// Shared definitions for the fixed-point ALU: op encodings, FSM states and the
// common clip-to-width helper.
package mp_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Wide enough for a 64-bit product plus rounding and a 63-bit signed quotient.
    localparam int unsigned SAT_W = 72;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_e;

    function automatic logic [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] val,
                                                  input int unsigned             width,
                                                  output logic                   clipped);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v    = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
        min_v    = ~max_v;
        clipped  = 1'b0;
        saturate = val;
        if (val > max_v) begin
            saturate = max_v;
            clipped  = 1'b1;
        end else if (val < min_v) begin
            saturate = min_v;
            clipped  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/mp_seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, DvdW iterations after start,
// done pulses for one cycle once the quotient is final.
module mp_seq_divider #(
    parameter int unsigned DvdW = 24,
    parameter int unsigned DsrW = 17
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [DvdW-1:0] dividend_i,
    input  logic [DsrW-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [DvdW-1:0] quotient_o
);

    localparam int unsigned CntW = (DvdW > 1) ? $clog2(DvdW) : 1;

    logic [DsrW-1:0] rem_q, rem_d;
    logic [DvdW-1:0] quo_q, quo_d;
    logic [DsrW-1:0] den_q, den_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [DsrW:0]   shifted;
    logic [DsrW+1:0] diff;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[DvdW-1]};
        diff    = {1'b0, shifted} - {2'b00, den_q};

        if (busy_q) begin
            // Remainder stays below the divisor, so the low DsrW bits hold it exactly.
            if (!diff[DsrW+1]) begin
                rem_d = diff[DsrW-1:0];
                quo_d = {quo_q[DvdW-2:0], 1'b1};
            end else begin
                rem_d = shifted[DsrW-1:0];
                quo_d = {quo_q[DvdW-2:0], 1'b0};
            end
            if (cnt_q == CntW'(DvdW - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            den_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/mp_fixed_alu.sv
// Signed Q-format ALU: single-cycle add/sub/mul with rounding and saturation,
// iterative divide, valid/ready on both sides.
module mp_fixed_alu
    import mp_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             sat,
    output logic             dz
);

    localparam int unsigned DvdW = WIDTH + FRAC;
    localparam int unsigned DsrW = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [SAT_W-1:0] MUL_ROUND = SAT_W'(64'd1 << (FRAC - 1));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sat_q, sat_d;
    logic             dz_q, dz_d;
    logic             neg_q, neg_d;

    logic signed [WIDTH:0]     add_res, sub_res;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [SAT_W-1:0]   mul_shift;
    logic [WIDTH:0]            mag_a, mag_b;
    logic [DvdW:0]             q_ext, div_signed;
    logic signed [SAT_W-1:0]   pre_sat;
    logic [SAT_W-1:0]          sat_val;
    logic                      sat_flag;

    logic            div_start, div_busy, div_done;
    logic [DvdW-1:0] div_quo;
    logic            unused_bits;

    always_comb begin
        add_res   = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        sub_res   = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        prod      = $signed(a) * $signed(b);
        mul_shift = (SAT_W'(prod) + MUL_ROUND) >>> FRAC;
        // WIDTH+1-bit magnitudes keep |min| representable.
        mag_a     = a[WIDTH-1] ? -{a[WIDTH-1], a} : {a[WIDTH-1], a};
        mag_b     = b[WIDTH-1] ? -{b[WIDTH-1], b} : {b[WIDTH-1], b};
        q_ext     = {1'b0, div_quo};
        div_signed = neg_q ? -q_ext : q_ext;

        if (state_q == DIV) begin
            pre_sat = SAT_W'($signed(div_signed));
        end else begin
            unique case (op)
                OP_ADD:  pre_sat = SAT_W'(add_res);
                OP_SUB:  pre_sat = SAT_W'(sub_res);
                OP_MUL:  pre_sat = mul_shift;
                default: pre_sat = '0;
            endcase
        end
        sat_val = saturate(pre_sat, WIDTH, sat_flag);
    end

    assign unused_bits = ^{sat_val[SAT_W-1:WIDTH], mag_a[WIDTH], div_busy};

    mp_seq_divider #(
        .DvdW(DvdW),
        .DsrW(DsrW)
    ) u_divider (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (div_start),
        .dividend_i({mag_a[WIDTH-1:0], {FRAC{1'b0}}}),
        .divisor_i (mag_b),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quo)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        sat_d     = sat_q;
        dz_d      = dz_q;
        neg_d     = neg_q;
        div_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sat_d = 1'b0;
                    dz_d  = 1'b0;
                    neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                    if (op == OP_DIV) begin
                        if (b == '0) begin
                            state_d  = DONE;
                            dz_d     = 1'b1;
                            sat_d    = 1'b1;
                            result_d = a[WIDTH-1] ? MIN_VAL : MAX_VAL;
                        end else begin
                            state_d   = DIV;
                            div_start = 1'b1;
                        end
                    end else begin
                        state_d  = DONE;
                        result_d = sat_val[WIDTH-1:0];
                        sat_d    = sat_flag;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d  = DONE;
                    result_d = sat_val[WIDTH-1:0];
                    sat_d    = sat_flag;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            sat_q    <= 1'b0;
            dz_q     <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            sat_q    <= sat_d;
            dz_q     <= dz_d;
            neg_q    <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign sat       = sat_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_mp_fixed_alu.sv
// Directed-vector bench for mp_fixed_alu at WIDTH=16, FRAC=8.
module tb_mp_fixed_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        sat;
    logic        dz;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mp_fixed_alu #(
        .WIDTH(16),
        .FRAC (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .sat      (sat),
        .dz       (dz)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, measure latency, check the result, then retire it.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] va,
                          input logic [15:0] vb, input logic [15:0] exp_res,
                          input logic exp_sat, input logic exp_dz, input int exp_lat);
        int lat;
        int busy_bad;
        lat      = 0;
        busy_bad = 0;
        op       = o;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid && in_ready) busy_bad++;
        end while (!out_valid && lat < 40);
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " in_ready low while busy"}, busy_bad, 0);
        check_eq({tag, " result"}, result, exp_res);
        check_eq({tag, " sat"}, sat, exp_sat);
        check_eq({tag, " dz"}, dz, exp_dz);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " in_ready after retire"}, in_ready, 1'b1);
    endtask

    initial begin
        int stable_bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        a         = 16'h0;
        b         = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset out_valid", out_valid, 1'b0);
        check_eq("reset result", result, 16'h0);
        check_eq("reset sat", sat, 1'b0);
        check_eq("reset dz", dz, 1'b0);
        check_eq("reset in_ready", in_ready, 1'b1);

        run_op("add", 2'b00, 16'h0180, 16'h0240, 16'h03C0, 1'b0, 1'b0, 1);
        run_op("add_ovf", 2'b00, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 1'b0, 1);
        run_op("sub_ovf", 2'b10, 16'h8100, 16'h0200, 16'h8000, 1'b1, 1'b0, 1);
        run_op("sub", 2'b10, 16'h0100, 16'h0300, 16'hFE00, 1'b0, 1'b0, 1);
        run_op("mul", 2'b01, 16'h0180, 16'hFE00, 16'hFD00, 1'b0, 1'b0, 1);
        run_op("mul_rnd", 2'b01, 16'h0001, 16'h0080, 16'h0001, 1'b0, 1'b0, 1);
        run_op("mul_sat", 2'b01, 16'h4000, 16'h4000, 16'h7FFF, 1'b1, 1'b0, 1);
        run_op("div", 2'b11, 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25);
        run_op("div_neg", 2'b11, 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25);
        run_op("div_sat", 2'b11, 16'h4000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 25);
        run_op("div_min", 2'b11, 16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25);
        run_op("div_zero", 2'b11, 16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1, 1);
        run_op("div_zero_pos", 2'b11, 16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1);
        run_op("add_clear", 2'b00, 16'h0100, 16'h0100, 16'h0200, 1'b0, 1'b0, 1);

        // Backpressure: result held while out_ready is low, new inputs ignored.
        op       = 2'b00;
        a        = 16'h7F00;
        b        = 16'h0200;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a          = 16'h0100;
        b          = 16'h0100;
        op         = 2'b01;
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (result !== 16'h7FFF || sat !== 1'b1 || dz !== 1'b0 || !out_valid || in_ready)
                stable_bad++;
        end
        check_eq("backpressure stable", stable_bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("backpressure release in_ready", in_ready, 1'b1);
        check_eq("backpressure release out_valid", out_valid, 1'b0);

        // Reset during a divide discards it.
        op       = 2'b11;
        a        = 16'h0300;
        b        = 16'h0200;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("mid-div reset out_valid", out_valid, 1'b0);
        check_eq("mid-div reset result", result, 16'h0);
        check_eq("mid-div reset in_ready", in_ready, 1'b1);
        run_op("add_after_rst", 2'b00, 16'h0180, 16'h0240, 16'h03C0, 1'b0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mp_fixed_alu.md
Name: mp_fixed_alu

Overview:
Parametrised fixed-point successor to the 16-bit mixed-precision ALU. It takes signed Qm.f operands of configurable width and fraction and performs add, sub, mul or div with rounding and saturation. Operands arrive on a valid/ready handshake. Add, sub and mul complete in one cycle; div runs as an iterative multi-cycle operation. It sits in the AI datapath between the operand fetch and the accumulator/writeback stage.

Parameters:
WIDTH, 16, operand/result width in bits, two's complement (4..32)
FRAC, 8, fractional bits of the Q format (1..WIDTH-2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand/op transfer valid
in_ready  output  1  block can accept (high only in IDLE)
op  input  2  00 add, 01 mul, 10 sub, 11 div
a  input  WIDTH  first operand, signed Q(WIDTH-FRAC).FRAC
b  input  WIDTH  second operand, same format
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  signed result, same Q format
sat  output  1  result was clipped to min/max
dz  output  1  divide by zero occurred

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: result=0, sat=0, dz=0, out_valid=0, FSM=IDLE, so in_ready=1 the cycle after reset. A reset in any state, including mid-divide, aborts the operation and discards it.
- Accept: transfer occurs when in_valid && in_ready. a, b and op are captured on that edge. Inputs are ignored while in_ready=0.
- FSM states: IDLE, DIV, DONE.
  - IDLE -> DONE on accept of add, sub or mul, or div with b==0.
  - IDLE -> DIV on accept of div with b!=0.
  - DIV -> DONE when the iteration counter reaches WIDTH+FRAC-1.
  - DONE -> IDLE when out_ready=1.
- out_valid equals (state==DONE). result, sat and dz are registered and stay stable while out_valid=1 && out_ready=0.
- Throughput: at most one op per 2 cycles. in_ready stays 0 in DONE even when out_ready=1; there is no bypass.
- Latency (accept edge k):
  - add/sub/mul/div-by-zero: out_valid high from edge k+1.
  - div: out_valid high from edge k+WIDTH+FRAC+1.
- Add/sub: computed at WIDTH+1 bits. Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set sat on clipping.
- Mul: full 2*WIDTH signed product. Add 2^(FRAC-1), then shift right arithmetically by FRAC (round half toward +inf). Saturate to WIDTH bits and set sat on clipping.
- Div: quotient = trunc_toward_zero((a<<FRAC)/b).
  - Restoring division on magnitudes: dividend |a|<<FRAC (WIDTH+FRAC bits), one quotient bit per cycle, WIDTH+FRAC iterations.
  - Sign = sign(a) XOR sign(b), applied after the last iteration, then saturate and set sat.
  - |min| is handled correctly by using WIDTH+1-bit magnitudes.
- Div by zero: dz=1. result is max positive for a>=0 and min negative for a<0. sat=1.
- sat and dz are cleared on every accept and describe only the current result.
- op is decoded as captured; all 4 encodings are legal.

Decomposition:
- Package mp_alu_pkg holds:
  - op encodings OP_ADD=2'b00, OP_MUL=2'b01, OP_SUB=2'b10, OP_DIV=2'b11
  - state enum IDLE/DIV/DONE
  - a saturate function that clips an N-bit signed value to WIDTH bits and returns a flag
- Sub-module mp_seq_divider: parametrised unsigned restoring divider with start, busy and done outputs and a fixed WIDTH+FRAC cycle count. The top level owns sign handling, saturation and the handshake.

Test Plan (WIDTH=16, FRAC=8):
- add: a=0x0180 (1.5), b=0x0240 (2.25), op=00 -> result=0x03C0, sat=0, out_valid one cycle after accept.
- add overflow: a=0x7F00, b=0x0200 -> result=0x7FFF, sat=1. sub: a=0x8100, b=0x0200 -> result=0x8000, sat=1.
- mul: a=0x0180, b=0xFE00 (-2.0), op=01 -> result=0xFD00, sat=0. Rounding: a=0x0001, b=0x0080 -> result=0x0001 (half rounded up).
- div: a=0x0300, b=0x0200, op=11 -> result=0x0180, out_valid exactly 25 cycles after accept, in_ready=0 throughout. a=0xFD00, b=0x0200 -> result=0xFE80. Div by zero: a=0xFF00, b=0 -> result=0x8000, dz=1, sat=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> result and flags stable, out_valid=1, in_ready=0, new in_valid ignored. Releasing out_ready gives in_ready=1 the next cycle.
- Reset mid-divide: assert rst at cycle 10 of a div -> next cycle out_valid=0, result=0, in_ready=1. The following add completes normally.
